// File: rtl/one_wire_slave_rx_if.sv
// rtl/one_wire_slave_rx_if.sv - local-side receive/status bundle of the 1-Wire slave receiver
`timescale 1ns/1ps
interface one_wire_slave_rx_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       reset_seen;
  logic       presence_active;
  logic       busy;

  // Receiver side drives the bundle
  modport master (
    output rx_byte, rx_valid, reset_seen, presence_active, busy
  );

  // Local consumer side
  modport slave (
    input rx_byte, rx_valid, reset_seen, presence_active, busy
  );
endinterface

// File: rtl/one_wire_slave_rx.sv
// rtl/one_wire_slave_rx.sv - 1-Wire slave: reset detect, presence pulse, LSB-first byte receive
`timescale 1ns/1ps
module one_wire_slave_rx #(
  parameter int CLK_MHZ  = 100,
  parameter int T_RSTDET = 400,
  parameter int T_PDH    = 15,
  parameter int T_PDL    = 60,
  parameter int T_SAMPLE = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire               one_wire_data,
  one_wire_slave_rx_if.master rx_if
);

  localparam logic [31:0] RSTDET_CYC = 32'(T_RSTDET * CLK_MHZ);
  localparam logic [31:0] PDH_CYC    = 32'(T_PDH * CLK_MHZ);
  localparam logic [31:0] PDL_CYC    = 32'(T_PDL * CLK_MHZ);
  localparam logic [31:0] SAMPLE_CYC = 32'(T_SAMPLE * CLK_MHZ);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_HOLD, S_PD_WAIT, S_PD_LOW, S_PD_REL,
    S_SLOT_IDLE, S_SLOT_LOW, S_SLOT_END
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic        line_s;
  logic [31:0] cnt_q;
  logic [31:0] low_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [6:0]  shift_q;
  logic [7:0]  rx_byte_q;
  logic        rx_valid_q;
  logic        sample_en;
  logic        byte_done;

  assign line_s = sync_q[1];

  // Two-flop synchroniser for the asynchronous bus level; idle bus reads high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], one_wire_data};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a long enough low pre-empts every state except our own presence drive
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      state_d = S_IDLE;
      S_RST_HOLD:  if (line_s)                state_d = S_PD_WAIT;
      S_PD_WAIT:   if (cnt_q >= PDH_CYC)      state_d = S_PD_LOW;
      S_PD_LOW:    if (cnt_q >= PDL_CYC)      state_d = S_PD_REL;
      S_PD_REL:    if (line_s)                state_d = S_SLOT_IDLE;
      S_SLOT_IDLE: if (!line_s)               state_d = S_SLOT_LOW;
      S_SLOT_LOW:  if (cnt_q == SAMPLE_CYC)   state_d = S_SLOT_END;
      S_SLOT_END:  if (line_s)                state_d = S_SLOT_IDLE;
      default:                                state_d = S_IDLE;
    endcase
    if (state_q != S_PD_LOW && state_q != S_RST_HOLD && low_cnt_q == RSTDET_CYC)
      state_d = S_RST_HOLD;
  end

  assign sample_en = (state_q == S_SLOT_LOW) && (state_d == S_SLOT_END);
  assign byte_done = sample_en && (bit_idx_q == 3'd7);

  // Per-state cycle counter and bus-low duration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      low_cnt_q <= '0;
    end else begin
      cnt_q     <= (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
      if (state_q == S_PD_LOW || line_s) low_cnt_q <= '0;
      else                               low_cnt_q <= low_cnt_q + 32'd1;
    end
  end

  // Bit assembly; a bus reset throws away any partial byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= byte_done;
      if (state_d == S_RST_HOLD) begin
        bit_idx_q <= '0;
        shift_q   <= '0;
      end else if (state_q == S_PD_REL && state_d == S_SLOT_IDLE) begin
        bit_idx_q <= '0;
      end else if (sample_en) begin
        bit_idx_q <= bit_idx_q + 3'd1;
        if (byte_done) rx_byte_q <= {line_s, shift_q};
        else           shift_q[bit_idx_q] <= line_s;
      end
    end
  end

  assign one_wire_data         = (state_q == S_PD_LOW) ? 1'b0 : 1'bz;
  assign rx_if.rx_byte         = rx_byte_q;
  assign rx_if.rx_valid        = rx_valid_q;
  assign rx_if.reset_seen      = (state_q == S_RST_HOLD) && line_s;
  assign rx_if.presence_active = (state_q == S_PD_LOW);
  assign rx_if.busy            = (state_q != S_IDLE) && (state_q != S_SLOT_IDLE);

endmodule

// File: doc/one_wire_slave_rx.md
Name: one_wire_slave_rx

Overview:
1-Wire slave-side responder/receiver, the far end of our 1-Wire master transmitter. It watches the open-drain bus, detects a master reset pulse, and answers with a presence pulse. It then decodes master write slots LSB-first into bytes and presents each completed byte to local logic with a one-cycle valid strobe.

Parameters:
CLK_MHZ, 100, clock frequency in MHz; every time constant below is converted to cycles as T_x * CLK_MHZ.
T_RSTDET, 400, minimum continuous low time (us) recognised as a master reset.
T_PDH, 15, wait (us) from end of reset pulse to start of presence pulse.
T_PDL, 60, presence pulse low duration (us).
T_SAMPLE, 30, delay (us) from slot falling edge to bit sample point.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
one_wire_data  inout  1  open-drain bus: driven 0 when pulling low, otherwise 'z'
rx_byte  output  8  last completed byte, LSB received first
rx_valid  output  1  one-cycle strobe; rx_byte is updated in the same cycle
reset_seen  output  1  one-cycle strobe when a valid reset pulse ends
presence_active  output  1  high while the DUT drives the presence pulse
busy  output  1  high in every state except S_IDLE and S_SLOT_IDLE

Behaviour:
- Reset is rst_n, asynchronous, active-low; the clock is clk. In reset: state=S_IDLE, bus released ('z'), rx_byte=0, rx_valid=0, reset_seen=0, presence_active=0, bit_idx=0, shift register=0, all counters=0.
- Input sync: bus is read through a 2-flop synchroniser (line_s). All timing and decoding use line_s, so there is 2 cycles of detection latency.
- Low counter low_cnt, 32 bits: increments while line_s==0, clears when line_s==1, and is held at 0 in S_PD_LOW. State counter cnt, 32 bits: clears on every state change, otherwise increments.
- Global reset detection: when low_cnt reaches RSTDET_CYC in any state other than S_PD_LOW, the next state is S_RST_HOLD. This overrides all other transitions. The partial byte is discarded, bit_idx=0, and rx_valid is not generated.
- States:
  - S_IDLE: bus released; leaves only via global reset detection. Lows shorter than RSTDET_CYC are ignored.
  - S_RST_HOLD: when line_s==1, go to S_PD_WAIT and pulse reset_seen for 1 cycle.
  - S_PD_WAIT: when cnt >= PDH_CYC, go to S_PD_LOW.
  - S_PD_LOW: drive the bus 0 and set presence_active=1; when cnt >= PDL_CYC, go to S_PD_REL.
  - S_PD_REL: bus released; when line_s==1, go to S_SLOT_IDLE with bit_idx=0.
  - S_SLOT_IDLE: when line_s==0 (falling edge), go to S_SLOT_LOW.
  - S_SLOT_LOW: at cnt == SAMPLE_CYC, sample line_s into shift[bit_idx] and go to S_SLOT_END. Sampling happens regardless of intermediate line activity. Sampled 1 means bit 1; sampled 0 means bit 0.
  - S_SLOT_END: when line_s==1, go to S_SLOT_IDLE.
- Byte completion: in the cycle bit 7 is sampled, set rx_byte <= {line_s, shift[6:0]} and rx_valid=1 for exactly that cycle, and wrap bit_idx to 0. Reception continues with further bytes until the next reset.
- Otherwise bit_idx increments by 1 per sampled bit (3-bit counter, wraps 7->0).
- rx_byte holds its value between strobes; a reset pulse on the bus does not clear it.
- A bus reset arriving during S_PD_WAIT or a slot re-enters S_RST_HOLD and repeats the presence sequence.
- rst_n mid-operation releases the bus immediately (asynchronous) and clears all outputs.

Test Plan:
- CLK_MHZ=10, master holds bus low 480 us then releases -> reset_seen single pulse 2 cycles after release; DUT pulls bus low from 15 us after release for 600 cycles; presence_active high exactly during that window.
- In S_IDLE, master pulls low for 100 us -> no reset_seen, no presence pulse, state stays S_IDLE.
- After presence, master writes 0xA5 (bit 1 = 6 us low, bit 0 = 60 us low, 60 us slot, 1 us recovery) -> exactly one rx_valid pulse, rx_byte=0xA5, strobe (SAMPLE_CYC+2) cycles after the bit-7 falling edge.
- Back-to-back bytes 0x3C then 0xFF -> two rx_valid pulses in order with rx_byte=0x3C then 0xFF; busy low between slots.
- Master sends 3 bits, then a 480 us reset, then byte 0x81 -> no rx_valid for the partial byte; new presence pulse; then rx_valid with rx_byte=0x81.
- rst_n asserted 20 us into the presence pulse -> bus released ('z') within the same cycle, presence_active=0, rx_byte=0; after rst_n release the DUT waits in S_IDLE for a fresh reset.
